stream_rr_arbiter: RTL and testbench
====================================

Name: stream_rr_arbiter

Overview:
- Packet-level round-robin arbiter. Shares one 2*32-bit AXI-Stream datapath, typically the 2:1 width downsizer, between N requesting stream sources.
- Grant is held for a whole packet, from first beat through the tlast beat.
- Output passes through one registered stage. Granted channel number is forwarded on out_tid.
- Sits directly upstream of the downsizer input port.

Parameters:
- N, 4, number of requesting input channels, range 2..16.
- W, 64, data width per channel; equals twice the downsizer output width.
- IDW, $clog2(N), width of channel-id fields. Derived; never overridden.

Ports:
- aclk  input  1  clock
- aresetn  input  1  asynchronous active-low reset
- in_tdata  input  N*W  packed channel data; channel i at [i*W +: W]
- in_tvalid  input  N  per-channel valid
- in_tlast  input  N  per-channel end-of-packet
- in_tready  output  N  per-channel ready; at most one bit high
- ch_enable  input  N  channel enable mask; sampled only in IDLE
- out_tdata  output  W  registered output data
- out_tlast  output  1  registered end-of-packet
- out_tid  output  IDW  registered source channel of the current beat
- out_tvalid  output  1  registered output valid
- out_tready  input  1  downstream ready
- busy  output  1  high while a packet grant is held

Behaviour:
- Reset: aresetn is asynchronous, active-low; clock aclk. While low:
  - state=IDLE
  - out_tvalid=0, out_tlast=0, out_tid=0
  - busy=0, in_tready=0
  - grant=0
  - last_grant=N-1, so channel 0 has top priority after reset.
  - out_tdata is not reset.
- FSM states: IDLE, BUSY.
- IDLE:
  - Eligible request: req[i] = in_tvalid[i] & ch_enable[i].
  - Winner: first set bit of req scanning last_grant+1, last_grant+2, ... modulo N (wrap-around).
  - If any req is set: grant<=winner, state<=BUSY.
  - If none: stay in IDLE; last_grant unchanged.
  - in_tready is all-zero in IDLE, so no beat transfers in the arbitration cycle.
- BUSY:
  - in_tready[grant] = ~out_tvalid | out_tready. All other bits are 0.
  - Accept = in_tvalid[grant] & in_tready[grant].
  - On accept: out_tdata<=channel data, out_tlast<=in_tlast[grant], out_tid<=grant, out_tvalid<=1.
  - On out_tvalid & out_tready without accept: out_tvalid<=0.
  - On accept with in_tlast[grant]=1: state<=IDLE, last_grant<=grant.
- busy = (state==BUSY).
- Latency:
  - Request present in IDLE at cycle k: grant at k+1, first beat may be accepted at k+1, visible on out_* at k+2.
  - Sustained throughput is 1 beat/cycle within a packet.
  - There is exactly one idle arbitration cycle between consecutive packets.
- Output register obeys AXI-Stream: out_tdata, out_tlast and out_tid are stable while out_tvalid & ~out_tready. out_tvalid never drops without a handshake.
- Boundary conditions:
  - Single-beat packet (tlast on first beat): BUSY lasts one cycle.
  - Granted source drops in_tvalid mid-packet: grant is held indefinitely; no other channel is served.
  - out_tready low: in_tready[grant] falls once the output register is full; no beat is lost or duplicated.
  - ch_enable change mid-packet: no effect until the next IDLE.
  - ch_enable all zero: stays in IDLE.
  - A request that drops during IDLE before being granted is not remembered.
  - All N channels requesting continuously: grants cycle 0,1,...,N-1,0 with no starvation.
  - Reset mid-packet: immediate return to reset state. The partial packet is discarded and tlast is not emitted.

Test Plan:
- Reset, then channel 2 sends a 3-beat packet A0..A2 with out_tready=1. Required: grant at cycle 1; out shows A0,A1,A2 on cycles 2..4 with out_tid=2 and tlast on A2; busy high on cycles 1..3.
- All 4 channels send 2-beat packets continuously. Required: out_tid sequence 0,0,1,1,2,2,3,3,0,0; exactly one bubble cycle between packets.
- Channel 1 packet in flight; out_tready toggled 1,0,0,1,1 each cycle. Required: data order preserved, out_* stable while stalled, no duplicated or lost beat.
- ch_enable=4'b1010 with all channels valid. Required: only channels 1 and 3 granted, alternating. Deassert bit 3 mid-packet: the packet still completes.
- Channel 0 drops in_tvalid for 5 cycles mid-packet while channel 1 requests. Required: channel 1 not granted until channel 0's tlast beat transfers.
- Assert aresetn=0 mid-packet on channel 3, then release. Required: out_tvalid=0 and busy=0 immediately; the next arbitration with channels 0 and 3 requesting grants channel 0.

Source files
------------

// File: rtl/stream_rr_arbiter.sv
// rtl/stream_rr_arbiter.sv - packet-level round-robin arbiter feeding one registered AXI-Stream output
module stream_rr_arbiter #(
  parameter int N = 4,
  parameter int W = 64,
  localparam int IDW = $clog2(N)
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic [N*W-1:0]   in_tdata,
  input  logic [N-1:0]     in_tvalid,
  input  logic [N-1:0]     in_tlast,
  output logic [N-1:0]     in_tready,
  input  logic [N-1:0]     ch_enable,
  output logic [W-1:0]     out_tdata,
  output logic             out_tlast,
  output logic [IDW-1:0]   out_tid,
  output logic             out_tvalid,
  input  logic             out_tready,
  output logic             busy
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t           state;
  state_t           state_next;
  logic [IDW-1:0]   grant;
  logic [IDW-1:0]   last_grant;
  logic [IDW-1:0]   winner;
  logic [IDW-1:0]   cand;
  logic [N-1:0]     req;
  logic             found;
  logic             accept;
  logic             pkt_end;
  logic [W-1:0]     ch_data [N];

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign ch_data[i] = in_tdata[i*W +: W];
  end

  assign req = in_tvalid & ch_enable;

  // Rotating priority: the scan starts just after the owner of the previous packet.
  always_comb begin
    winner = '0;
    cand   = '0;
    found  = 1'b0;
    for (int k = 1; k <= N; k++) begin
      cand = IDW'((int'(last_grant) + k) % N);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  assign accept  = in_tvalid[grant] & in_tready[grant];
  assign pkt_end = accept & in_tlast[grant];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (found) state_next = BUSY;
      BUSY:    if (pkt_end) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == BUSY);
    in_tready = '0;
    if (state == BUSY) begin
      in_tready[grant] = ~out_tvalid | out_tready;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      grant      <= '0;
      last_grant <= IDW'(N - 1);
    end else begin
      if (state == IDLE && found) grant <= winner;
      if (pkt_end) last_grant <= grant;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      out_tvalid <= 1'b0;
      out_tlast  <= 1'b0;
      out_tid    <= '0;
    end else if (accept) begin
      out_tvalid <= 1'b1;
      out_tlast  <= in_tlast[grant];
      out_tid    <= grant;
    end else if (out_tready) begin
      out_tvalid <= 1'b0;
    end
  end

  // Data register carries no reset; it is only meaningful while out_tvalid is high.
  always_ff @(posedge aclk) begin
    if (accept) out_tdata <= ch_data[grant];
  end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// tb/tb_stream_rr_arbiter.sv - directed self-checking bench for stream_rr_arbiter
module tb_stream_rr_arbiter;
  localparam int N   = 4;
  localparam int W   = 64;
  localparam int IDW = 2;

  logic           aclk = 1'b0;
  logic           aresetn;
  logic [N*W-1:0] in_tdata;
  logic [N-1:0]   in_tvalid;
  logic [N-1:0]   in_tlast;
  logic [N-1:0]   in_tready;
  logic [N-1:0]   ch_enable;
  logic [W-1:0]   out_tdata;
  logic           out_tlast;
  logic [IDW-1:0] out_tid;
  logic           out_tvalid;
  logic           out_tready;
  logic           busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc;
  int npk [N];
  int len [N];
  int beat [N];
  int pkt [N];
  bit gate [N];

  logic [IDW-1:0] q_tid [$];
  logic [W-1:0]   q_data [$];
  logic           q_last [$];

  stream_rr_arbiter #(.N(N), .W(W)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tlast(in_tlast), .in_tready(in_tready),
    .ch_enable(ch_enable),
    .out_tdata(out_tdata), .out_tlast(out_tlast), .out_tid(out_tid),
    .out_tvalid(out_tvalid), .out_tready(out_tready), .busy(busy)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] enc(input int ch, input int p, input int b);
    return {8'(ch), 24'(p), 32'(b)};
  endfunction

  function automatic logic [63:0] g_tid(input int k);
    return (k < q_tid.size()) ? 64'(q_tid[k]) : '1;
  endfunction

  function automatic logic [63:0] g_data(input int k);
    return (k < q_data.size()) ? q_data[k] : '1;
  endfunction

  function automatic logic [63:0] g_last(input int k);
    return (k < q_last.size()) ? 64'(q_last[k]) : '1;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      in_tvalid[i]        = (npk[i] > 0) && gate[i];
      in_tlast[i]         = (beat[i] == len[i] - 1);
      in_tdata[i*W +: W]  = enc(i, pkt[i], beat[i]);
    end
  endtask

  task automatic clr_src();
    for (int i = 0; i < N; i++) begin
      npk[i] = 0; len[i] = 1; beat[i] = 0; pkt[i] = 0; gate[i] = 1'b1;
    end
    q_tid.delete(); q_data.delete(); q_last.delete();
  endtask

  // One clock: note handshakes due at the coming edge, then advance the sources.
  task automatic tick();
    logic [N-1:0] acc;
    acc = in_tvalid & in_tready;
    if (out_tvalid && out_tready) begin
      q_tid.push_back(out_tid); q_data.push_back(out_tdata); q_last.push_back(out_tlast);
    end
    @(posedge aclk); #1;
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        if (beat[i] == len[i] - 1) begin
          beat[i] = 0; pkt[i]++; npk[i]--;
        end else begin
          beat[i]++;
        end
      end
    end
    drive();
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    ch_enable = '1;
    out_tready = 1'b1;
    clr_src();
    drive();
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    cyc = 0;
  endtask

  initial begin
    int ech [8];
    int epk [8];
    bit rdy_tbl [9];
    aresetn = 1'b0;
    ch_enable = '1;
    out_tready = 1'b1;
    clr_src();
    drive();

    // Test 1: single 3-beat packet on channel 2
    do_reset();
    chk("rst_busy", 64'(busy), 0);
    chk("rst_vld", 64'(out_tvalid), 0);
    chk("rst_last", 64'(out_tlast), 0);
    chk("rst_tid", 64'(out_tid), 0);
    chk("rst_rdy", 64'(in_tready), 0);
    npk[2] = 1; len[2] = 3; drive();
    #1 chk("t1_c0_rdy", 64'(in_tready), 0);
    tick();
    chk("t1_c1_busy", 64'(busy), 1);
    chk("t1_c1_rdy", 64'(in_tready), 64'h4);
    chk("t1_c1_vld", 64'(out_tvalid), 0);
    for (int b = 0; b < 3; b++) begin
      tick();
      chk("t1_vld", 64'(out_tvalid), 1);
      chk("t1_tid", 64'(out_tid), 2);
      chk("t1_data", out_tdata, enc(2, 0, b));
      chk("t1_last", 64'(out_tlast), 64'(b == 2));
      chk("t1_busy", 64'(busy), 64'(b != 2));
    end
    tick();
    chk("t1_drain", 64'(out_tvalid), 0);

    // Test 2: all channels streaming 2-beat packets, one bubble between packets
    do_reset();
    for (int i = 0; i < N; i++) begin npk[i] = 3; len[i] = 2; end
    drive();
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (c >= 2) chk("t2_vld", 64'(out_tvalid), 64'(((c - 2) % 3) != 2));
    end
    for (int k = 0; k < 10; k++) begin
      chk("t2_tid", g_tid(k), 64'((k / 2) % 4));
      chk("t2_data", g_data(k), enc((k / 2) % 4, k / 8, k % 2));
    end

    // Test 3: output stall while channel 1 streams
    do_reset();
    npk[1] = 1; len[1] = 4; drive();
    rdy_tbl = '{1, 1, 1, 0, 0, 1, 1, 1, 1};
    for (int c = 0; c <= 8; c++) begin
      out_tready = rdy_tbl[c];
      #1;
      if (c == 3 || c == 4) begin
        chk("t3_stall_rdy", 64'(in_tready), 0);
        chk("t3_stall_vld", 64'(out_tvalid), 1);
        chk("t3_stall_data", out_tdata, enc(1, 0, 1));
      end
      tick();
    end
    chk("t3_count", 64'(q_data.size()), 4);
    for (int k = 0; k < 4; k++) begin
      chk("t3_data", g_data(k), enc(1, 0, k));
      chk("t3_last", g_last(k), 64'(k == 3));
    end

    // Test 4: enable mask 1010, bit 3 cleared during channel 3's packet
    do_reset();
    ch_enable = 4'b1010;
    for (int i = 0; i < N; i++) begin npk[i] = 10; len[i] = 2; end
    drive();
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (cyc == 4) begin
        chk("t4_grant3", 64'(in_tready), 64'h8);
        ch_enable = 4'b0010;
      end
    end
    ech = '{1, 1, 3, 3, 1, 1, 1, 1};
    epk = '{0, 0, 0, 0, 1, 1, 2, 2};
    for (int k = 0; k < 8; k++) begin
      chk("t4_tid", g_tid(k), 64'(ech[k]));
      chk("t4_data", g_data(k), enc(ech[k], epk[k], k % 2));
    end
    chk("t4_last3", g_last(3), 1);

    // Test 5: channel 0 stalls mid-packet while channel 1 waits
    do_reset();
    npk[0] = 1; len[0] = 3; npk[1] = 1; len[1] = 1; drive();
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (cyc == 2) gate[0] = 1'b0;
      if (cyc == 7) gate[0] = 1'b1;
      drive();
      #1;
      if (cyc <= 8) chk("t5_hold", 64'(in_tready), 64'h1);
      if (cyc == 9) chk("t5_idle", 64'(busy), 0);
      if (cyc == 10) chk("t5_grant1", 64'(in_tready), 64'h2);
    end
    for (int k = 0; k < 4; k++) begin
      chk("t5_tid", g_tid(k), 64'(k == 3));
      chk("t5_data", g_data(k), (k == 3) ? enc(1, 0, 0) : enc(0, 0, k));
    end

    // Test 6: reset in the middle of channel 3's packet
    do_reset();
    npk[3] = 1; len[3] = 4; drive();
    tick(); tick();
    chk("t6_inflight", 64'(out_tvalid), 1);
    aresetn = 1'b0;
    #1;
    chk("t6_rst_vld", 64'(out_tvalid), 0);
    chk("t6_rst_last", 64'(out_tlast), 0);
    chk("t6_rst_busy", 64'(busy), 0);
    chk("t6_rst_rdy", 64'(in_tready), 0);
    @(posedge aclk); #1;
    clr_src();
    aresetn = 1'b1;
    cyc = 0;
    npk[0] = 1; npk[3] = 1; drive();
    tick();
    chk("t6_grant0", 64'(in_tready), 64'h1);
    tick();
    chk("t6_out_tid", 64'(out_tid), 0);
    chk("t6_out_data", out_tdata, enc(0, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
